// File: rtl/drum_voice.sv
// Percussive pad voice: debounces the touch pad code and plays a square-wave
// burst per strike, pitch set by the pad, loudness decaying linearly via PWM.
module drum_voice #(
  parameter int unsigned DEBOUNCE  = 50000,
  parameter int unsigned DECAY_DIV = 200000,
  parameter int unsigned TONE_BASE = 95556,
  parameter int unsigned TONE_STEP = 5000
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       speaker,
  output logic       active,
  output logic [3:0] cur_pad
);

  localparam int unsigned SW = $clog2((DEBOUNCE > 1) ? DEBOUNCE : 2);
  localparam int unsigned DW = $clog2((DECAY_DIV > 1) ? DECAY_DIV : 2);
  localparam int unsigned HW = 17;
  localparam int unsigned AW = 8;
  localparam int unsigned PW = 4;

  localparam logic [SW-1:0] STAB_MAX  = SW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DECAY_MAX = DW'(DECAY_DIV - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  logic [PW-1:0] w_key_raw;
  logic [PW-1:0] r_key_prev;
  logic [SW-1:0] r_stab_cnt;
  logic [PW-1:0] r_key_q;
  logic [PW-1:0] r_key_q_d;

  logic          w_strike;
  logic [HW-1:0] w_half;
  logic          w_tone_wrap;
  logic          w_decay_wrap;

  state_t        r_state;
  logic [HW-1:0] r_half;
  logic [HW-1:0] r_tone_cnt;
  logic          r_tone_ph;
  logic [DW-1:0] r_decay_cnt;
  logic [AW-1:0] r_amp;
  logic [AW-1:0] r_pwm_cnt;
  logic          r_speaker;
  logic          r_active;
  logic [PW-1:0] r_cur_pad;

  // Codes 13..15 are not pads and behave exactly like "no touch".
  assign w_key_raw = (key > 4'd12) ? 4'd0 : key;

  // Debounce: accept a code once it has been seen unchanged DEBOUNCE times.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_key_prev <= '0;
      r_stab_cnt <= '0;
      r_key_q    <= '0;
      r_key_q_d  <= '0;
    end else begin
      r_key_prev <= w_key_raw;
      r_key_q_d  <= r_key_q;
      if (w_key_raw != r_key_prev) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt == STAB_MAX) begin
        r_key_q <= w_key_raw;
      end else begin
        r_stab_cnt <= r_stab_cnt + SW'(1);
      end
    end
  end

  // A strike is the debounced code moving to a new nonzero pad.
  assign w_strike = (r_key_q != 4'd0) && (r_key_q != r_key_q_d);

  assign w_half = HW'(TONE_BASE - (32'(r_key_q) - 32'd1) * TONE_STEP);

  assign w_tone_wrap  = (r_tone_cnt == (r_half - HW'(1)));
  assign w_decay_wrap = (r_decay_cnt == DECAY_MAX);

  // Voice state machine; a strike always restarts, even on the final decay step.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_half      <= '0;
      r_tone_cnt  <= '0;
      r_tone_ph   <= 1'b0;
      r_decay_cnt <= '0;
      r_amp       <= '0;
      r_pwm_cnt   <= '0;
      r_speaker   <= 1'b0;
      r_active    <= 1'b0;
      r_cur_pad   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + AW'(1);
      r_speaker <= (r_state == S_PLAY) && r_tone_ph && (r_pwm_cnt < r_amp);

      if (w_strike) begin
        r_state     <= S_PLAY;
        r_active    <= 1'b1;
        r_cur_pad   <= r_key_q;
        r_half      <= w_half;
        r_amp       <= AW'(255);
        r_tone_cnt  <= '0;
        r_tone_ph   <= 1'b1;
        r_decay_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_active    <= 1'b0;
            r_amp       <= '0;
            r_tone_cnt  <= '0;
            r_tone_ph   <= 1'b0;
            r_decay_cnt <= '0;
          end
          S_PLAY: begin
            if (w_tone_wrap) begin
              r_tone_cnt <= '0;
              r_tone_ph  <= ~r_tone_ph;
            end else begin
              r_tone_cnt <= r_tone_cnt + HW'(1);
            end

            if (w_decay_wrap) begin
              r_decay_cnt <= '0;
              if (r_amp == AW'(1)) begin
                r_state    <= S_IDLE;
                r_active   <= 1'b0;
                r_amp      <= '0;
                r_tone_cnt <= '0;
                r_tone_ph  <= 1'b0;
              end else begin
                r_amp <= r_amp - AW'(1);
              end
            end else begin
              r_decay_cnt <= r_decay_cnt + DW'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign speaker = r_speaker;
  assign active  = r_active;
  assign cur_pad = r_cur_pad;

endmodule
